// File: rtl/pacman_move_ctrl_if.sv
// Bus between the Pac-Man move controller, its frame/player inputs,
// the legal-move checker and the renderer.
//
// Handshake: frame_tick is a one-cycle request pulse with no ready;
// the controller samples it only when busy is low and drops it otherwise.
// The checker has no valid/ready either: legal_moves is trusted
// LOOKUP_LAT cycles after xpos/ypos/query_dir were last changed, and the
// controller keeps all three stable for that whole window. moved is a
// one-cycle strobe issued in the same cycle that xpos/ypos show the new
// position.
interface pacman_move_ctrl_if;
    logic       frame_tick;
    logic [3:0] req_dir;
    logic [3:0] legal_moves;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic [3:0] query_dir;
    logic [3:0] cur_dir;
    logic       busy;
    logic       moved;

    modport master (
        input  frame_tick, req_dir, legal_moves,
        output xpos, ypos, query_dir, cur_dir, busy, moved
    );

    modport slave (
        output frame_tick, req_dir, legal_moves,
        input  xpos, ypos, query_dir, cur_dir, busy, moved
    );
endinterface

// File: rtl/pacman_move_ctrl.sv
// Pac-Man position/direction controller.
// Each accepted frame tick asks the legal-move checker about the requested
// direction and/or the current one, then steps the sprite by STEP pixels.
// Optional build macro PACMAN_TUNNEL_WRAP_EN: the horizontal axis wraps
// around (tunnel) instead of clamping; the vertical axis always clamps.
module pacman_move_ctrl #(
    parameter logic [9:0] START_X    = 10'd170,
    parameter logic [9:0] START_Y    = 10'd54,
    parameter logic [3:0] STEP       = 4'd2,
    parameter int         LOOKUP_LAT = 3,
    parameter logic [9:0] X_MIN      = 10'd150,
    parameter logic [9:0] X_MAX      = 10'd610,
    parameter logic [9:0] Y_MIN      = 10'd34,
    parameter logic [9:0] Y_MAX      = 10'd494
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pacman_move_ctrl_if.master        bus,
    output logic [1:0]                state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        Q_REQ = 2'd1,
        Q_CUR = 2'd2,
        STEP_S = 2'd3
    } state_t;

    localparam int CW = (LOOKUP_LAT < 2) ? 1 : $clog2(LOOKUP_LAT);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOOKUP_LAT - 1);

    localparam logic signed [10:0] X_MIN_S = {1'b0, X_MIN};
    localparam logic signed [10:0] X_MAX_S = {1'b0, X_MAX};
    localparam logic signed [10:0] Y_MIN_S = {1'b0, Y_MIN};
    localparam logic signed [10:0] Y_MAX_S = {1'b0, Y_MAX};
    localparam logic signed [10:0] STEP_S11 = {7'd0, STEP};

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    req_q, req_n;
    logic [3:0]    query_q, query_n;
    logic [3:0]    cur_q, cur_n;
    logic [9:0]    x_q, x_n;
    logic [9:0]    y_q, y_n;
    logic          moved_q, moved_n;

    logic signed [10:0] x_dec, x_inc, y_dec, y_inc;
    logic [9:0]         step_x, step_y;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    assign x_dec = $signed({1'b0, x_q}) - STEP_S11;
    assign x_inc = $signed({1'b0, x_q}) + STEP_S11;
    assign y_dec = $signed({1'b0, y_q}) - STEP_S11;
    assign y_inc = $signed({1'b0, y_q}) + STEP_S11;

    // Candidate position for a step along cur_dir, with clamp or tunnel wrap.
    always_comb begin
        step_x = x_q;
        step_y = y_q;
        unique case (cur_q)
            4'b0001: begin
                if (x_dec < X_MIN_S) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
                    step_x = X_MAX;
`else
                    step_x = X_MIN;
`endif
                end else begin
                    step_x = x_dec[9:0];
                end
            end
            4'b0010: begin
                if (x_inc > X_MAX_S) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
                    step_x = X_MIN;
`else
                    step_x = X_MAX;
`endif
                end else begin
                    step_x = x_inc[9:0];
                end
            end
            4'b0100: step_y = (y_dec < Y_MIN_S) ? Y_MIN : y_dec[9:0];
            4'b1000: step_y = (y_inc > Y_MAX_S) ? Y_MAX : y_inc[9:0];
            default: ;
        endcase
    end

    // Next-state and next-output decision for the move FSM.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        req_n   = req_q;
        query_n = query_q;
        cur_n   = cur_q;
        x_n     = x_q;
        y_n     = y_q;
        moved_n = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (bus.frame_tick) begin
                    req_n = bus.req_dir;
                    if (is_onehot(bus.req_dir)) begin
                        query_n = bus.req_dir;
                        state_n = Q_REQ;
                    end else if (cur_q != 4'd0) begin
                        query_n = cur_q;
                        state_n = Q_CUR;
                    end
                end
            end
            Q_REQ: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if ((bus.legal_moves & req_q) != 4'd0) begin
                        cur_n   = req_q;
                        state_n = STEP_S;
                    end else if (cur_q != 4'd0) begin
                        query_n = cur_q;
                        state_n = Q_CUR;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            Q_CUR: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if ((bus.legal_moves & cur_q) != 4'd0) begin
                        state_n = STEP_S;
                    end else begin
                        cur_n   = 4'd0;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STEP_S: begin
                x_n     = step_x;
                y_n     = step_y;
                moved_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            req_q   <= 4'd0;
            query_q <= 4'd0;
            cur_q   <= 4'd0;
            x_q     <= START_X;
            y_q     <= START_Y;
            moved_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            req_q   <= req_n;
            query_q <= query_n;
            cur_q   <= cur_n;
            x_q     <= x_n;
            y_q     <= y_n;
            moved_q <= moved_n;
        end
    end

    assign bus.xpos      = x_q;
    assign bus.ypos      = y_q;
    assign bus.query_dir = query_q;
    assign bus.cur_dir   = cur_q;
    assign bus.busy      = (state != IDLE);
    assign bus.moved     = moved_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Self-checking bench for pacman_move_ctrl: directed scenarios plus a
// randomized run against a frame-level reference model.
module tb_pacman_move_ctrl;

    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] state_dbg;

    pacman_move_ctrl_if bus();

    pacman_move_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: position and committed direction.
    int         m_x, m_y;
    logic [3:0] m_cur;
    logic [23:0] exp_q[$];

    // Frame-level model: which queries happen, whether a move happens,
    // and when moved/busy are expected relative to the tick cycle.
    task automatic model_frame(input logic [3:0] req, input logic [3:0] legal,
                               output int exp_moved_at, output int exp_idle_at);
        int         queries;
        bit         mv;
        logic [3:0] dir;
        queries = 0;
        mv      = 0;
        dir     = 4'd0;
        if ($countones(req) == 1) begin
            queries = 1;
            if ((legal & req) != 4'd0) begin
                mv    = 1;
                dir   = req;
                m_cur = req;
            end
        end
        if (!mv && m_cur != 4'd0) begin
            queries++;
            if ((legal & m_cur) != 4'd0) begin
                mv  = 1;
                dir = m_cur;
            end else begin
                m_cur = 4'd0;
            end
        end
        if (mv) begin
            case (dir)
                4'b0001: begin
                    m_x = m_x - 2;
`ifdef PACMAN_TUNNEL_WRAP_EN
                    if (m_x < 150) m_x = 610;
`else
                    if (m_x < 150) m_x = 150;
`endif
                end
                4'b0010: begin
                    m_x = m_x + 2;
`ifdef PACMAN_TUNNEL_WRAP_EN
                    if (m_x > 610) m_x = 150;
`else
                    if (m_x > 610) m_x = 610;
`endif
                end
                4'b0100: begin
                    m_y = m_y - 2;
                    if (m_y < 34) m_y = 34;
                end
                default: begin
                    m_y = m_y + 2;
                    if (m_y > 494) m_y = 494;
                end
            endcase
        end
        exp_moved_at = mv ? queries * LAT + 2 : 0;
        exp_idle_at  = (queries == 0) ? 1 : queries * LAT + (mv ? 1 : 0) + 1;
    endtask

    // Clock/reset driver.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.frame_tick  = 1'b0;
        bus.req_dir     = 4'd0;
        bus.legal_moves = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_x   = 170;
        m_y   = 54;
        m_cur = 4'd0;
    endtask

    // Driver: one frame tick, then a bounded 12-cycle observation window.
    // Cycle 1 is the first cycle after the edge that sampled the tick.
    task automatic run_frame(input logic [3:0] req, input logic [3:0] legal,
                             input bit scramble, output int moved_cnt,
                             output int moved_at, output int idle_at);
        @(posedge clk);
        #1;
        bus.req_dir     = req;
        bus.legal_moves = legal;
        bus.frame_tick  = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        moved_cnt = 0;
        moved_at  = 0;
        idle_at   = 0;
        for (int c = 1; c <= 12; c++) begin
            if (scramble) bus.req_dir = 4'($urandom);
            if (bus.moved === 1'b1) begin
                moved_cnt++;
                if (moved_at == 0) moved_at = c;
            end
            if (idle_at == 0 && bus.busy === 1'b0) idle_at = c;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int mc, ma, ia;
        int seen_moved;
        do_reset();
        tests_run++;
        if ({bus.xpos, bus.ypos} !== {10'd170, 10'd54}) begin
            tests_failed++;
            $display("FAIL reset_pos: got x=%0d y=%0d, want x=170 y=54", bus.xpos, bus.ypos);
        end
        tests_run++;
        if ({bus.query_dir, bus.cur_dir, bus.busy, bus.moved} !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got q=%b cur=%b busy=%b moved=%b, want all 0",
                     bus.query_dir, bus.cur_dir, bus.busy, bus.moved);
        end
        // Move once so reset has something to undo.
        run_frame(4'b0010, 4'b0010, 1'b0, mc, ma, ia);
        @(posedge clk);
        #1;
        bus.req_dir    = 4'b0010;
        bus.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_pre_busy: got busy=%b, want 1", bus.busy);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.xpos, bus.ypos, bus.cur_dir, bus.busy, bus.moved} !== {10'd170, 10'd54, 4'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_mid_qreq: got x=%0d y=%0d cur=%b busy=%b moved=%b, want 170 54 0000 0 0",
                     bus.xpos, bus.ypos, bus.cur_dir, bus.busy, bus.moved);
        end
        seen_moved = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (bus.moved === 1'b1) seen_moved++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (bus.moved === 1'b1) seen_moved++;
        end
        tests_run++;
        if (seen_moved != 0 || bus.xpos !== 10'd170) begin
            tests_failed++;
            $display("FAIL reset_no_move: got moved pulses=%0d x=%0d, want 0 and 170", seen_moved, bus.xpos);
        end
    endtask

    task automatic test_legal_turn();
        int mc, ma, ia;
        do_reset();
        run_frame(4'b0010, 4'b0010, 1'b0, mc, ma, ia);
        tests_run++;
        if (mc != 1 || ma != LAT + 2) begin
            tests_failed++;
            $display("FAIL turn_timing: got pulses=%0d at=%0d, want 1 at %0d", mc, ma, LAT + 2);
        end
        tests_run++;
        if (bus.xpos !== 10'd172 || bus.cur_dir !== 4'b0010 || bus.query_dir !== 4'b0010) begin
            tests_failed++;
            $display("FAIL turn_result: got x=%0d cur=%b q=%b, want 172 0010 0010",
                     bus.xpos, bus.cur_dir, bus.query_dir);
        end
    endtask

    task automatic test_continue();
        int mc, ma, ia;
        // Continues from test_legal_turn: moving right at x=172.
        run_frame(4'b0100, 4'b0010, 1'b0, mc, ma, ia);
        tests_run++;
        if (mc != 1 || ma != 2 * LAT + 2) begin
            tests_failed++;
            $display("FAIL continue_timing: got pulses=%0d at=%0d, want 1 at %0d", mc, ma, 2 * LAT + 2);
        end
        tests_run++;
        if (bus.xpos !== 10'd174 || bus.ypos !== 10'd54 || bus.cur_dir !== 4'b0010) begin
            tests_failed++;
            $display("FAIL continue_result: got x=%0d y=%0d cur=%b, want 174 54 0010",
                     bus.xpos, bus.ypos, bus.cur_dir);
        end
    endtask

    task automatic test_blocked();
        int mc, ma, ia;
        do_reset();
        run_frame(4'b1000, 4'b1000, 1'b0, mc, ma, ia);
        tests_run++;
        if (bus.ypos !== 10'd56 || bus.cur_dir !== 4'b1000) begin
            tests_failed++;
            $display("FAIL blocked_setup: got y=%0d cur=%b, want 56 1000", bus.ypos, bus.cur_dir);
        end
        run_frame(4'b0000, 4'b0000, 1'b0, mc, ma, ia);
        tests_run++;
        if (mc != 0 || bus.cur_dir !== 4'b0000 || bus.ypos !== 10'd56) begin
            tests_failed++;
            $display("FAIL blocked_result: got pulses=%0d cur=%b y=%0d, want 0 0000 56", mc, bus.cur_dir, bus.ypos);
        end
        tests_run++;
        if (ia != LAT + 1) begin
            tests_failed++;
            $display("FAIL blocked_busy: got busy low at cycle %0d, want %0d", ia, LAT + 1);
        end
        // Non-one-hot request while stopped: no query at all.
        run_frame(4'b0011, 4'b1111, 1'b0, mc, ma, ia);
        tests_run++;
        if (mc != 0 || ia != 1 || bus.xpos !== 10'd170) begin
            tests_failed++;
            $display("FAIL nonhot_idle: got pulses=%0d idle_at=%0d x=%0d, want 0 1 170", mc, ia, bus.xpos);
        end
    endtask

    task automatic test_busy_drop();
        int pulses;
        do_reset();
        @(posedge clk);
        #1;
        bus.req_dir     = 4'b0010;
        bus.legal_moves = 4'b0010;
        bus.frame_tick  = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            bus.frame_tick = (c == 2);
            if (bus.moved === 1'b1) pulses++;
            @(posedge clk);
            #1;
        end
        bus.frame_tick = 1'b0;
        tests_run++;
        if (pulses != 1 || bus.xpos !== 10'd172) begin
            tests_failed++;
            $display("FAIL busy_drop: got pulses=%0d x=%0d, want 1 172", pulses, bus.xpos);
        end
    endtask

    task automatic test_edges();
        int mc, ma, ia;
        do_reset();
        for (int i = 0; i < 10; i++) run_frame(4'b0001, 4'b0001, 1'b0, mc, ma, ia);
        tests_run++;
        if (bus.xpos !== 10'd150) begin
            tests_failed++;
            $display("FAIL edge_reach_xmin: got x=%0d, want 150", bus.xpos);
        end
        run_frame(4'b0001, 4'b0001, 1'b0, mc, ma, ia);
        tests_run++;
`ifdef PACMAN_TUNNEL_WRAP_EN
        if (mc != 1 || bus.xpos !== 10'd610) begin
            tests_failed++;
            $display("FAIL edge_left_wrap: got pulses=%0d x=%0d, want 1 610", mc, bus.xpos);
        end
`else
        if (mc != 1 || bus.xpos !== 10'd150) begin
            tests_failed++;
            $display("FAIL edge_left_clamp: got pulses=%0d x=%0d, want 1 150", mc, bus.xpos);
        end
`endif
        for (int i = 0; i < 11; i++) run_frame(4'b0100, 4'b0100, 1'b0, mc, ma, ia);
        tests_run++;
        if (mc != 1 || bus.ypos !== 10'd34) begin
            tests_failed++;
            $display("FAIL edge_top_clamp: got pulses=%0d y=%0d, want 1 34", mc, bus.ypos);
        end
    endtask

    task automatic test_random();
        int          mc, ma, ia, ema, eia, kind;
        logic [3:0]  req, legal;
        logic [23:0] exp_v;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0:       req = 4'd0;
                4:       req = 4'($urandom);
                default: req = 4'(1 << $urandom_range(0, 3));
            endcase
            legal = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) legal = legal | req;
            model_frame(req, legal, ema, eia);
            exp_q.push_back({10'(m_x), 10'(m_y), m_cur});
            run_frame(req, legal, ($urandom_range(0, 1) == 1), mc, ma, ia);
            exp_v = exp_q.pop_front();
            tests_run++;
            if (ma != ema || mc != ((ema != 0) ? 1 : 0)) begin
                tests_failed++;
                $display("FAIL rand_moved[%0d]: got pulses=%0d at=%0d, want at=%0d (req=%b legal=%b)",
                         n, mc, ma, ema, req, legal);
            end
            tests_run++;
            if (ia != eia) begin
                tests_failed++;
                $display("FAIL rand_busy[%0d]: got idle at %0d, want %0d", n, ia, eia);
            end
            tests_run++;
            if ({bus.xpos, bus.ypos, bus.cur_dir} !== exp_v) begin
                tests_failed++;
                $display("FAIL rand_state[%0d]: got x=%0d y=%0d cur=%b, want x=%0d y=%0d cur=%b",
                         n, bus.xpos, bus.ypos, bus.cur_dir, exp_v[23:14], exp_v[13:4], exp_v[3:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_legal_turn();
        test_continue();
        test_blocked();
        test_busy_drop();
        test_edges();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pacman_move_ctrl.md
Name: pacman_move_ctrl

Overview:
- Position/direction owner for the Pac-Man sprite; sits on the driving end of the legal-move lookup.
- Drives the pixel position and a query direction into the legal-move checker, and reads back its 4-bit `legal_moves` mask after a fixed lookup latency.
- On each frame tick, decides whether to turn to the player-requested direction, continue in the current one, or stop.
- Then steps the position and reports the move to the renderer.

Parameters:
- START_X, 10'd170, reset x pixel (top-left of sprite)
- START_Y, 10'd54, reset y pixel
- STEP, 4'd2, pixels moved per accepted tick
- LOOKUP_LAT, 3, clk cycles from a stable xpos/ypos/query_dir to a valid legal_moves
- X_MIN, 10'd150, leftmost legal x
- X_MAX, 10'd610, rightmost legal x (150 + 8*60 - 20)
- Y_MIN, 10'd34, topmost legal y
- Y_MAX, 10'd494, bottom legal y (34 + 8*60 - 20)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per frame; requests one move decision
- req_dir  in  4  player request, one-hot {down,up,right,left}; 0 = none
- legal_moves  in  4  checker result {down,up,right,left}, valid LOOKUP_LAT cycles after query
- xpos  out  10  sprite x, registered
- ypos  out  10  sprite y, registered
- query_dir  out  4  direction presented to checker, registered
- cur_dir  out  4  committed travel direction, one-hot or 0 (stopped)
- busy  out  1  high while not in IDLE
- moved  out  1  one-cycle pulse when xpos/ypos updated

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: xpos=START_X, ypos=START_Y, query_dir=0, cur_dir=0, busy=0, moved=0, FSM=IDLE, wait counter=0. Reset mid-operation aborts immediately with no position update.
- FSM states: IDLE, Q_REQ, Q_CUR, STEP.
- IDLE:
  - On frame_tick, sample req_dir into an internal register.
  - If the sample is one-hot, set query_dir=req and go to Q_REQ.
  - Else, if cur_dir≠0, set query_dir=cur_dir and go to Q_CUR.
  - Else stay in IDLE; busy stays 0.
- Q_REQ: hold query_dir and xpos/ypos stable; count LOOKUP_LAT cycles. On the final count, evaluate legal_moves & req:
  - nonzero → cur_dir<=req, go to STEP;
  - zero and cur_dir≠0 → query_dir<=cur_dir, restart the counter, go to Q_CUR;
  - zero and cur_dir=0 → go to IDLE.
- Q_CUR: wait LOOKUP_LAT cycles, then evaluate legal_moves & cur_dir:
  - nonzero → go to STEP;
  - zero → cur_dir<=0 (stop), go to IDLE.
- STEP: apply ±STEP on the axis of cur_dir (left −x, right +x, up −y, down +y), pulse moved for one cycle, go to IDLE.
  - Decision cycle: Q_REQ best case = 1 (IDLE) + LOOKUP_LAT + 1 (STEP).
- Width and clamp rules: arithmetic is 11-bit signed. A result below the MIN is clamped to MIN; above the MAX, clamped to MAX. A clamped move still pulses moved.
- frame_tick while busy=1: ignored and dropped, not queued.
- req_dir changes during Q_REQ have no effect (sampled value used).
- req_dir equal to cur_dir: handled as a normal Q_REQ.
- Non-one-hot req_dir (e.g. 4'b0011): treated as no request.
- query_dir holds its last value in IDLE.

Optional Feature:
- Macro: PACMAN_TUNNEL_WRAP_EN.
- When defined, the horizontal axis wraps instead of clamping:
  - a left step whose result is < X_MIN sets xpos=X_MAX;
  - a right step whose result is > X_MAX sets xpos=X_MIN.
- The vertical axis always clamps.
- When undefined, both axes clamp as described under Behaviour.

Test Plan:
- Reset: assert rst_n=0 mid-Q_REQ → xpos=170, ypos=54, cur_dir=0, busy=0 within the same cycle, no moved pulse.
- Legal turn: cur_dir=0, req_dir=4'b0010, legal_moves=4'b0010 held → moved pulses LOOKUP_LAT+2 cycles after tick; xpos=172, cur_dir=4'b0010.
- Illegal request, continue: cur_dir=right, req_dir=up, legal_moves=4'b0010 → Q_REQ then Q_CUR; xpos +2; cur_dir stays right; moved at cycle 2*LOOKUP_LAT+2.
- Blocked: cur_dir=down, req_dir=0, legal_moves=4'b0000 → no moved pulse, cur_dir=0, ypos unchanged, busy falls after LOOKUP_LAT+1.
- Busy drop: second frame_tick two cycles after the first → exactly one moved pulse, one STEP applied.
- Edge: xpos=151, cur_dir=left, legal → xpos=150 (clamp); with PACMAN_TUNNEL_WRAP_EN and xpos=150, a left step → xpos=610.
